calc_ctrl_gen: RTL
==================

Name: calc_ctrl_gen

Overview:
Parametrised successor to the single-mode calculator controller. It streams operand pairs from a dual-bank SRAM (bank A holds the lower DATA_W bits, bank B the upper DATA_W bits, same address), applies a selectable 2*DATA_W-bit operation, and writes results into a circular write window. It adds a start/done handshake, configurable SRAM read latency, odd-count handling, write wrap-around, sticky carry/error status, and a cycle counter. It sits inside top_lvl between the testbench-driven address ports and the two SRAM instances.

Parameters:
DATA_W, 32, width of one bank word; operand/result width is 2*DATA_W
ADDR_W, 10, SRAM address width
RD_LAT, 1, SRAM read latency in cycles (>=1)
CNT_W, 32, cycle_count width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  level; sampled only in S_IDLE and S_END
mode  in  2  op_e: 0 ADD, 1 SUB (A-B), 2 XOR, 3 PASS (A only)
read_start_addr  in  ADDR_W  first operand address, inclusive
read_end_addr  in  ADDR_W  last operand address, inclusive
write_start_addr  in  ADDR_W  write window start, inclusive
write_end_addr  in  ADDR_W  write window end, inclusive
rd_en  out  1  SRAM read strobe, both banks
rd_addr  out  ADDR_W  SRAM read address
rd_data_lo  in  DATA_W  bank A read data
rd_data_hi  in  DATA_W  bank B read data
wr_en  out  1  SRAM write strobe, both banks
w_addr  out  ADDR_W  SRAM write address
wr_data_lo  out  DATA_W  result[DATA_W-1:0]
wr_data_hi  out  DATA_W  result[2*DATA_W-1:DATA_W]
busy  out  1  high outside S_IDLE/S_END
done  out  1  high in S_END
carry_flag  out  1  sticky: any ADD carry-out or SUB borrow this run
wrap_flag  out  1  sticky: write address wrapped at least once this run
err_flag  out  1  read_end_addr < read_start_addr or write_end_addr < write_start_addr at start
cycle_count  out  CNT_W  cycles spent from leaving S_IDLE to entering S_END

Behaviour:
- Reset: state S_IDLE; all outputs 0; w_addr 0; internal registers cleared. Reset mid-run aborts immediately, and no further wr_en is issued.
- On start in S_IDLE or S_END: capture all four addresses and mode, clear flags and cycle_count, load r_ptr=read_start, w_addr=write_start, then go to S_READ_A. If a range is invalid, set err_flag and go directly to S_END, with no SRAM access.
- S_READ_A: rd_en=1, rd_addr=r_ptr; next S_WAIT_A.
- S_WAIT_A: hold RD_LAT cycles via latency counter; capture {rd_data_hi,rd_data_lo} into op_a on the last cycle.
- If r_ptr==read_end (odd count), set op_b=0 and go to S_CALC. Otherwise r_ptr++ and go to S_READ_B.
- S_READ_B / S_WAIT_B: same as A, capturing into op_b.
- S_CALC: result register = op(op_a, op_b), truncated to 2*DATA_W. ADD carry-out or SUB borrow sets carry_flag. XOR and PASS never set it.
- S_WRITE: wr_en=1 for exactly 1 cycle with w_addr and result.
- After the write: if w_addr==write_end, w_addr<=write_start and set wrap_flag; else w_addr++.
- Next state: S_END if the pair consumed read_end; else r_ptr++ and go to S_READ_A.
- Cycles per full pair = 2*(1+RD_LAT)+2 (6 at RD_LAT=1). The odd last operand takes 1+RD_LAT+2.
- cycle_count increments every cycle while busy and saturates at all-ones. It holds its value in S_END.
- S_END: done=1, and outputs hold. start re-launches as above. Without start, the block stays in S_END.
- read_end==read_start: single operand, one write of op_a op 0.
- rd_en and wr_en are never high in the same cycle.
- Address increments wrap modulo 2^ADDR_W only through the explicit window logic; r_ptr never passes read_end.

Decomposition:
- calculator_pkg: ADDR_W, DATA_W defaults, op_e enum, state_e enum (S_IDLE, S_READ_A, S_WAIT_A, S_READ_B, S_WAIT_B, S_CALC, S_WRITE, S_END).
- One sub-module, calc_alu: combinational, takes op_a, op_b and mode, produces result and carry. The FSM, pointers and counters stay in calc_ctrl_gen.

Test Plan:
- ADD, RD_LAT=1, read 0..511, write 768..1023, operand[i]={i,i}: 256 writes; w_addr 768+k holds {4k+1,4k+1}; carry_flag=0; cycle_count=1536; done=1.
- SUB, read 0..1, op_a=5, op_b=7 → w_addr=write_start holds 2^(2*DATA_W)-2; carry_flag=1.
- Wrap: read 0..9 (5 pairs), write window 100..102 → writes to 100,101,102,100,101; wrap_flag=1; final w_addr=102.
- Odd count: read 0..2, PASS, RD_LAT=3 → two writes, the second = operand[2]; total cycles 10+6=16.
- err_flag: read_start=10, read_end=5, start → S_END next cycle, no rd_en/wr_en, err_flag=1, cycle_count=0.
- Reset mid-run: assert rst during S_WAIT_B of pair 3 → next cycle S_IDLE, all outputs 0, no further writes; restart completes correctly.

Source files
------------

// File: rtl/calc_ctrl_gen_pkg.sv
// Shared types and defaults for the calculator controller slice.
package calculator_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 10;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_XOR  = 2'd2,
        OP_PASS = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_A,
        S_WAIT_A,
        S_READ_B,
        S_WAIT_B,
        S_CALC,
        S_WRITE,
        S_END
    } state_e;

endpackage

// File: rtl/calc_ctrl_gen_if.sv
// Dual-bank SRAM bus: one read port and one write port shared by both banks.
interface calc_ctrl_gen_if
    import calculator_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data_lo;
    logic [DATA_W-1:0] rd_data_hi;
    logic              wr_en;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] wr_data_lo;
    logic [DATA_W-1:0] wr_data_hi;

    modport master (
        output rd_en, rd_addr, wr_en, w_addr, wr_data_lo, wr_data_hi,
        input  rd_data_lo, rd_data_hi
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, w_addr, wr_data_lo, wr_data_hi,
        output rd_data_lo, rd_data_hi
    );

endinterface

// File: rtl/calc_ctrl_gen_alu.sv
// Combinational operand ALU; carry reports ADD carry-out or SUB borrow only.
module calc_alu
    import calculator_pkg::*;
#(
    parameter int W = 2 * DATA_W_DEF
) (
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  op_e          mode,
    output logic [W-1:0] result,
    output logic         carry
);

    logic [W:0] sum;
    logic [W:0] diff;

    assign sum  = {1'b0, op_a} + {1'b0, op_b};
    assign diff = {1'b0, op_a} - {1'b0, op_b};

    // Select the operation; the extra top bit of the wide add/sub is the flag.
    always_comb begin
        result = op_a;
        carry  = 1'b0;
        unique case (mode)
            OP_ADD:  begin result = sum[W-1:0];  carry = sum[W];  end
            OP_SUB:  begin result = diff[W-1:0]; carry = diff[W]; end
            OP_XOR:  result = op_a ^ op_b;
            OP_PASS: result = op_a;
            default: result = op_a;
        endcase
    end

endmodule

// File: rtl/calc_ctrl_gen.sv
// Streams operand pairs from a dual-bank SRAM through calc_alu and writes the
// results into a circular write window, with start/done handshake and status.
module calc_ctrl_gen
    import calculator_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] read_start_addr,
    input  logic [ADDR_W-1:0] read_end_addr,
    input  logic [ADDR_W-1:0] write_start_addr,
    input  logic [ADDR_W-1:0] write_end_addr,
    calc_ctrl_gen_if.master   sram,
    output logic              busy,
    output logic              done,
    output logic              carry_flag,
    output logic              wrap_flag,
    output logic              err_flag,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int OP_W  = 2 * DATA_W;
    localparam int LAT_W = $clog2(RD_LAT + 1);

    state_e            state, state_n;
    op_e               mode_q;
    logic [ADDR_W-1:0] r_ptr, rd_end_q, wr_start_q, wr_end_q, w_addr_q;
    logic [OP_W-1:0]   op_a, op_b, result_q, alu_res;
    logic              alu_carry;
    logic [LAT_W-1:0]  lat_cnt;
    logic              lat_last, at_end, range_err;

    // Range check uses the live inputs so an invalid launch never touches SRAM.
    assign range_err = (read_end_addr < read_start_addr) || (write_end_addr < write_start_addr);
    assign lat_last  = (lat_cnt == LAT_W'(RD_LAT - 1));
    assign at_end    = (r_ptr == rd_end_q);

    calc_alu #(.W(OP_W)) u_alu (
        .op_a   (op_a),
        .op_b   (op_b),
        .mode   (mode_q),
        .result (alu_res),
        .carry  (alu_carry)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next-state: read A, optionally read B, compute, write, loop or finish.
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE, S_END: if (start) state_n = range_err ? S_END : S_READ_A;
            S_READ_A:      state_n = S_WAIT_A;
            S_WAIT_A:      if (lat_last) state_n = at_end ? S_CALC : S_READ_B;
            S_READ_B:      state_n = S_WAIT_B;
            S_WAIT_B:      if (lat_last) state_n = S_CALC;
            S_CALC:        state_n = S_WRITE;
            S_WRITE:       state_n = at_end ? S_END : S_READ_A;
            default:       state_n = S_IDLE;
        endcase
    end

    // Datapath: launch capture, operand capture, result, pointers, flags, counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= OP_ADD;
            r_ptr       <= '0;
            rd_end_q    <= '0;
            wr_start_q  <= '0;
            wr_end_q    <= '0;
            w_addr_q    <= '0;
            op_a        <= '0;
            op_b        <= '0;
            result_q    <= '0;
            lat_cnt     <= '0;
            carry_flag  <= 1'b0;
            wrap_flag   <= 1'b0;
            err_flag    <= 1'b0;
            cycle_count <= '0;
        end else begin
            // Saturating run-time counter; frozen outside the busy states.
            if (busy && !(&cycle_count)) cycle_count <= cycle_count + 1'b1;

            unique case (state)
                S_IDLE, S_END: begin
                    if (start) begin
                        mode_q      <= op_e'(mode);
                        r_ptr       <= read_start_addr;
                        rd_end_q    <= read_end_addr;
                        wr_start_q  <= write_start_addr;
                        wr_end_q    <= write_end_addr;
                        w_addr_q    <= write_start_addr;
                        carry_flag  <= 1'b0;
                        wrap_flag   <= 1'b0;
                        err_flag    <= range_err;
                        cycle_count <= '0;
                    end
                end
                S_READ_A, S_READ_B: lat_cnt <= '0;
                S_WAIT_A: begin
                    if (lat_last) begin
                        op_a <= {sram.rd_data_hi, sram.rd_data_lo};
                        // Odd trailing operand pairs with zero.
                        if (at_end) op_b <= '0;
                        else        r_ptr <= r_ptr + 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                S_WAIT_B: begin
                    if (lat_last) op_b <= {sram.rd_data_hi, sram.rd_data_lo};
                    else          lat_cnt <= lat_cnt + 1'b1;
                end
                S_CALC: begin
                    result_q <= alu_res;
                    if (alu_carry) carry_flag <= 1'b1;
                end
                S_WRITE: begin
                    if (w_addr_q == wr_end_q) begin
                        w_addr_q  <= wr_start_q;
                        wrap_flag <= 1'b1;
                    end else begin
                        w_addr_q <= w_addr_q + 1'b1;
                    end
                    if (!at_end) r_ptr <= r_ptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy            = (state != S_IDLE) && (state != S_END);
    assign done            = (state == S_END);
    assign sram.rd_en      = (state == S_READ_A) || (state == S_READ_B);
    assign sram.rd_addr    = r_ptr;
    assign sram.wr_en      = (state == S_WRITE);
    assign sram.w_addr     = w_addr_q;
    assign sram.wr_data_lo = result_q[DATA_W-1:0];
    assign sram.wr_data_hi = result_q[OP_W-1:DATA_W];

endmodule
